wu_mem_cntl: RTL

- Owns the single-port WU instruction SRAM and decides which requester uses it each cycle.
- Requester 1 is WU fetch reads: one address per cycle, with stall feedback.
- Requester 2 is system/host writes that load WU programs: a data/valid/ready handshake.
- Sits between wu_fetch, the system config path and the WU SRAM macro. It returns read data, tagged with its address, to the WU decoder.

---
 rtl/wu_mem_cntl_pkg.sv | 14 +
 rtl/wum_fifo.sv | 47 ++++
 rtl/wu_mem_cntl.sv | 117 +++++++++++
 3 files changed

// File: rtl/wu_mem_cntl_pkg.sv
// wu_mem_cntl_pkg: shared grant encodings, default sizing and starve counter width for the WU memory controller
package wu_mem_cntl_pkg;
  typedef enum logic [1:0] {
    WUM_ARB_IDLE     = 2'd0,
    WUM_ARB_RD       = 2'd1,
    WUM_ARB_WR       = 2'd2,
    WUM_ARB_WR_FORCE = 2'd3
  } wum_arb_e;
  localparam int WUM_RD_SKID_DEPTH = 4;
  localparam int WUM_WR_FIFO_DEPTH = 4;
  localparam int WUM_STALL_THRESH  = 1;
  localparam int WUM_WR_STARVE_MAX = 8;
  localparam int WUM_STARVE_W      = $clog2(WUM_WR_STARVE_MAX + 1);
endpackage

// File: rtl/wum_fifo.sv
// wum_fifo: synchronous FIFO with full/empty/occupancy; a push while full is taken only together with a pop
module wum_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en, rd_en;
  always_comb begin
    full_o  = cnt_q == CW'(DEPTH);
    empty_o = cnt_q == '0;
    count_o = cnt_q;
    rdata_o = mem_q[rptr_q];
    rd_en   = pop_i & ~empty_o;
    wr_en   = push_i & (~full_o | rd_en);
    wptr_d  = wr_en ? ((wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1)) : wptr_q;
    rptr_d  = rd_en ? ((rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1)) : rptr_q;
    cnt_d   = cnt_q + CW'(wr_en) - CW'(rd_en);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/wu_mem_cntl.sv
// wu_mem_cntl: arbitrates the single-port WU SRAM between in-order fetch reads (via a skid) and queued host writes
module wu_mem_cntl
  import wu_mem_cntl_pkg::*;
#(
  parameter int WU_ADDR_W     = 24,
  parameter int WU_DATA_W     = 64,
  parameter int RD_SKID_DEPTH = WUM_RD_SKID_DEPTH,
  parameter int WR_FIFO_DEPTH = WUM_WR_FIFO_DEPTH,
  parameter int STALL_THRESH  = WUM_STALL_THRESH,
  parameter int WR_STARVE_MAX = WUM_WR_STARVE_MAX
) (
  input  logic                 clk,
  input  logic                 reset_poweron_n,
  input  logic                 wuf__wum__read,
  input  logic [WU_ADDR_W-1:0] wuf__wum__addr,
  output logic                 wum__wuf__stall,
  input  logic                 sys__wum__write,
  input  logic [WU_ADDR_W-1:0] sys__wum__addr,
  input  logic [WU_DATA_W-1:0] sys__wum__data,
  output logic                 wum__sys__ready,
  output logic                 wum__sram__cs,
  output logic                 wum__sram__we,
  output logic [WU_ADDR_W-1:0] wum__sram__addr,
  output logic [WU_DATA_W-1:0] wum__sram__wdata,
  input  logic [WU_DATA_W-1:0] sram__wum__rdata,
  output logic                 wum__dec__valid,
  output logic [WU_DATA_W-1:0] wum__dec__data,
  output logic [WU_ADDR_W-1:0] wum__dec__addr,
  output logic                 wum__mcntl__err
);
  localparam int SCW = $clog2(RD_SKID_DEPTH + 1);
  localparam int WCW = $clog2(WR_FIFO_DEPTH + 1);
  localparam int SW  = $clog2(WR_STARVE_MAX + 1);

  wum_arb_e                       grant;
  logic                           skid_push, skid_pop, skid_full, skid_empty, bypass, ovf;
  logic [WU_ADDR_W-1:0]           skid_head;
  logic [SCW-1:0]                 skid_cnt, occ_next;
  logic                           wq_push, wq_full, wq_empty, wr_force, rd_pend, wr_issue, rd_issue;
  logic [WU_ADDR_W+WU_DATA_W-1:0] wq_head;
  logic [WCW-1:0]                 wq_cnt;
  logic [SW-1:0]                  starve_q, starve_d;
  logic                           cs_q, cs_d, we_q, we_d, stall_q, stall_d, err_q, err_d, dv_q;
  logic [WU_ADDR_W-1:0]           addr_q, addr_d, dec_addr_q;
  logic [WU_DATA_W-1:0]           wdata_q, wdata_d;

  wum_fifo #(.W(WU_ADDR_W), .DEPTH(RD_SKID_DEPTH)) u_rd_skid (
    .clk(clk), .rst_n(reset_poweron_n), .push_i(skid_push), .pop_i(skid_pop),
    .wdata_i(wuf__wum__addr), .rdata_o(skid_head), .full_o(skid_full),
    .empty_o(skid_empty), .count_o(skid_cnt)
  );

  wum_fifo #(.W(WU_ADDR_W + WU_DATA_W), .DEPTH(WR_FIFO_DEPTH)) u_wr_q (
    .clk(clk), .rst_n(reset_poweron_n), .push_i(wq_push), .pop_i(wr_issue),
    .wdata_i({sys__wum__addr, sys__wum__data}), .rdata_o(wq_head), .full_o(wq_full),
    .empty_o(wq_empty), .count_o(wq_cnt)
  );

  always_comb begin
    wum__sys__ready = wq_cnt != WCW'(WR_FIFO_DEPTH);
    wq_push   = sys__wum__write & wum__sys__ready;
    wr_force  = ~wq_empty & (wq_full | (starve_q == SW'(WR_STARVE_MAX)));
    rd_pend   = ~skid_empty | wuf__wum__read;
    grant     = wr_force ? WUM_ARB_WR_FORCE : rd_pend ? WUM_ARB_RD : ~wq_empty ? WUM_ARB_WR : WUM_ARB_IDLE;
    wr_issue  = (grant == WUM_ARB_WR) | (grant == WUM_ARB_WR_FORCE);
    rd_issue  = grant == WUM_ARB_RD;
    // an incoming read that finds the skid empty goes straight to the SRAM
    bypass    = rd_issue & skid_empty;
    skid_pop  = rd_issue & ~skid_empty;
    skid_push = wuf__wum__read & ~bypass;
    ovf       = skid_push & skid_full & ~skid_pop;
    occ_next  = skid_cnt + SCW'(skid_push & ~ovf) - SCW'(skid_pop);
    stall_d   = (occ_next >= SCW'(STALL_THRESH)) | (grant == WUM_ARB_WR_FORCE);
    err_d     = err_q | ovf;
    starve_d  = (wr_issue | wq_empty) ? '0 : (rd_issue & (starve_q != SW'(WR_STARVE_MAX))) ? starve_q + SW'(1) : starve_q;
    cs_d      = grant != WUM_ARB_IDLE;
    we_d      = wr_issue;
    addr_d    = wr_issue ? wq_head[WU_ADDR_W+WU_DATA_W-1:WU_DATA_W] : bypass ? wuf__wum__addr : rd_issue ? skid_head : '0;
    wdata_d   = wr_issue ? wq_head[WU_DATA_W-1:0] : '0;
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
      starve_q   <= '0;
      dv_q       <= 1'b0;
      dec_addr_q <= '0;
    end else begin
      cs_q       <= cs_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
      starve_q   <= starve_d;
      dv_q       <= cs_q & ~we_q;
      dec_addr_q <= (cs_q & ~we_q) ? addr_q : '0;
    end
  end

  always_comb begin
    wum__wuf__stall  = stall_q;
    wum__mcntl__err  = err_q;
    wum__sram__cs    = cs_q;
    wum__sram__we    = we_q;
    wum__sram__addr  = addr_q;
    wum__sram__wdata = wdata_q;
    wum__dec__valid  = dv_q;
    wum__dec__addr   = dec_addr_q;
    wum__dec__data   = dv_q ? sram__wum__rdata : '0;
  end
endmodule
